// File: rtl/vga_scanout.sv
// VGA scan-out engine: H/V timing counters, pixel fetch requests issued FETCH_LATENCY
// cycles ahead of display, and registered colour/sync/DE pins with underflow detection.
module vga_scanout #(
  parameter int H_DISPLAY     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int COLORS        = 3,
  parameter int COLOR_DEPTH   = 8,
  parameter int FETCH_LATENCY = 2,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter bit SWAP_RB       = 1'b0,
  parameter logic [3*COLOR_DEPTH-1:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int DATA_WIDTH = COLORS * COLOR_DEPTH,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic                   clk_25mhz,
  input  logic                   rst,
  input  logic                   en,
  output logic                   req_valid,
  output logic [HW-1:0]          req_x,
  output logic [VW-1:0]          req_y,
  input  logic [DATA_WIDTH-1:0]  pixel_data,
  input  logic                   pixel_valid,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [COLOR_DEPTH-1:0] vga_r,
  output logic [COLOR_DEPTH-1:0] vga_g,
  output logic [COLOR_DEPTH-1:0] vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_de,
  output logic                   underflow,
  input  logic                   clear_underflow
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;

  // Returns {R,G,B}; green always comes from the middle field.
  function automatic logic [3*COLOR_DEPTH-1:0] map_pixel(input logic [DATA_WIDTH-1:0] d);
    logic [COLOR_DEPTH-1:0] lo, mid, hi;
    lo  = d[COLOR_DEPTH-1:0];
    mid = d[2*COLOR_DEPTH-1:COLOR_DEPTH];
    hi  = d[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
    return SWAP_RB ? {hi, mid, lo} : {lo, mid, hi};
  endfunction

  logic          en_eff;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          vld_p0, hs_p0, vs_p0;
  logic          vld_p1, hs_p1, vs_p1;

  // Reset holds the request side quiet even if en is already high.
  assign en_eff = en & ~rst;

  always_ff @(posedge clk_25mhz) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage p0: request decode straight from the counters
  assign req_x       = en_eff ? h_cnt : '0;
  assign req_y       = en_eff ? v_cnt : '0;
  assign vld_p0      = en_eff && (int'(h_cnt) < H_DISPLAY) && (int'(v_cnt) < V_DISPLAY);
  assign hs_p0       = en_eff && (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
  assign vs_p0       = en_eff && (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
  assign req_valid   = vld_p0;
  assign frame_start = en_eff && (h_cnt == '0) && (v_cnt == '0);
  assign line_start  = en_eff && (h_cnt == '0);

  // Stage p1: control delayed to line up with the returning pixel
  generate
    if (FETCH_LATENCY == 0) begin : g_no_dly
      assign {vld_p1, hs_p1, vs_p1} = {vld_p0, hs_p0, vs_p0};
    end else begin : g_dly
      logic [2:0] dly_p1 [FETCH_LATENCY];
      always_ff @(posedge clk_25mhz) begin
        if (rst) begin
          for (int i = 0; i < FETCH_LATENCY; i++) dly_p1[i] <= '0;
        end else begin
          dly_p1[0] <= {vld_p0, hs_p0, vs_p0};
          for (int i = 1; i < FETCH_LATENCY; i++) dly_p1[i] <= dly_p1[i-1];
        end
      end
      assign {vld_p1, hs_p1, vs_p1} = dly_p1[FETCH_LATENCY-1];
    end
  endgenerate

  // Stage p2: registered pins
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      vga_de    <= 1'b0;
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      underflow <= 1'b0;
    end else begin
      vga_de    <= vld_p1;
      vga_hsync <= hs_p1 ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync <= vs_p1 ? VSYNC_POL : ~VSYNC_POL;
      if (vld_p1 && pixel_valid)
        {vga_r, vga_g, vga_b} <= map_pixel(pixel_data);
      else if (vld_p1)
        {vga_r, vga_g, vga_b} <= UNDERFLOW_COLOR;
      else
        {vga_r, vga_g, vga_b} <= '0;
      if (vld_p1 && !pixel_valid)
        underflow <= 1'b1;
      else if (clear_underflow)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout: two instances (FL=2/SWAP_RB=0 and FL=0/SWAP_RB=1) on a
// 12x7 timing, compared cycle by cycle against a position-based reference model.
module tb_vga_scanout;

  localparam int HD = 8, HF = 1, HS = 2, HB = 1;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int NCYC = 1600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        clear_underflow = 1'b0;
  logic [23:0] pixel_data = '0;

  logic       rv [2];
  logic [3:0] rx [2];
  logic [2:0] ry [2];
  logic       fs [2];
  logic       ls [2];
  logic [7:0] vr [2];
  logic [7:0] vg [2];
  logic [7:0] vb [2];
  logic       vh [2];
  logic       vv [2];
  logic       vde [2];
  logic       uf [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    vga_scanout #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .FETCH_LATENCY(k == 0 ? 2 : 0),
      .SWAP_RB(k == 1)
    ) u_dut (
      .clk_25mhz(clk),
      .rst(rst),
      .en(en),
      .req_valid(rv[k]),
      .req_x(rx[k]),
      .req_y(ry[k]),
      .pixel_data(pixel_data),
      .pixel_valid(pixel_valid),
      .frame_start(fs[k]),
      .line_start(ls[k]),
      .vga_r(vr[k]),
      .vga_g(vg[k]),
      .vga_b(vb[k]),
      .vga_hsync(vh[k]),
      .vga_vsync(vv[k]),
      .vga_de(vde[k]),
      .underflow(uf[k]),
      .clear_underflow(clear_underflow)
    );
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle history of model requests and bench inputs.
  bit          m_de  [NCYC];
  bit          m_hs  [NCYC];
  bit          m_vs  [NCYC];
  bit          m_rst [NCYC];
  bit          m_pv  [NCYC];
  bit          m_clr [NCYC];
  logic [23:0] m_pd  [NCYC];
  bit          uf_m  [2];

  // Pins seen after the edge that closes cycle j.
  task automatic verify_pins(input int k, input int j);
    int fl;
    bit live, de_d, hs_d, vs_d;
    logic [7:0] er, eg, eb, lo, hi;
    fl = (k == 0) ? 2 : 0;
    live = (j - fl >= 0);
    for (int i = j - fl; i <= j; i++)
      if (i >= 0 && m_rst[i]) live = 1'b0;
    de_d = 1'b0; hs_d = 1'b0; vs_d = 1'b0;
    if (live) begin
      de_d = m_de[j-fl];
      hs_d = m_hs[j-fl];
      vs_d = m_vs[j-fl];
    end
    if (m_rst[j]) uf_m[k] = 1'b0;
    else if (de_d && !m_pv[j]) uf_m[k] = 1'b1;
    else if (m_clr[j]) uf_m[k] = 1'b0;
    lo = m_pd[j][7:0];
    hi = m_pd[j][23:16];
    if (de_d && m_pv[j]) begin
      eg = m_pd[j][15:8];
      er = (k == 1) ? hi : lo;
      eb = (k == 1) ? lo : hi;
    end else if (de_d) begin
      er = 8'hFF; eg = 8'h00; eb = 8'hFF;
    end else begin
      er = 8'h00; eg = 8'h00; eb = 8'h00;
    end
    check($sformatf("u%0d vga_de", k),    32'(vde[k]), 32'(de_d));
    check($sformatf("u%0d vga_hsync", k), 32'(vh[k]),  32'(!hs_d));
    check($sformatf("u%0d vga_vsync", k), 32'(vv[k]),  32'(!vs_d));
    check($sformatf("u%0d vga_r", k),     32'(vr[k]),  32'(er));
    check($sformatf("u%0d vga_g", k),     32'(vg[k]),  32'(eg));
    check($sformatf("u%0d vga_b", k),     32'(vb[k]),  32'(eb));
    check($sformatf("u%0d underflow", k), 32'(uf[k]),  32'(uf_m[k]));
  endtask

  initial begin
    int pos, pcur, hx, vy;
    bit eff, e_rv, e_fs, e_ls;
    pos = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst = (c < 3) || (c == 1000);
      en = !((c >= 3 && c < 8) || (c >= 300 && c < 304) ||
             (c >= 505 && c < 512) || (c >= 777 && c < 779));
      pixel_valid = (c < 200) ? 1'b1 : ($urandom_range(0, 15) != 0);
      pixel_data = (c >= 100 && c < 300) ? 24'h0000FF : 24'($urandom);
      clear_underflow = (c < 200) ? 1'b0 : ($urandom_range(0, 7) == 0);

      eff  = en && !rst;
      pcur = eff ? pos : 0;
      hx   = pcur % HT;
      vy   = pcur / HT;
      e_rv = eff && hx < HD && vy < VD;
      e_fs = eff && pcur == 0;
      e_ls = eff && hx == 0;
      m_de[c]  = e_rv;
      m_hs[c]  = eff && hx >= HD + HF && hx < HD + HF + HS;
      m_vs[c]  = eff && vy >= VD + VF && vy < VD + VF + VS;
      m_rst[c] = rst;
      m_pv[c]  = pixel_valid;
      m_clr[c] = clear_underflow;
      m_pd[c]  = pixel_data;

      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d req_valid", k),   32'(rv[k]), 32'(e_rv));
        check($sformatf("u%0d req_x", k),       32'(rx[k]), 32'(eff ? hx : 0));
        check($sformatf("u%0d req_y", k),       32'(ry[k]), 32'(eff ? vy : 0));
        check($sformatf("u%0d frame_start", k), 32'(fs[k]), 32'(e_fs));
        check($sformatf("u%0d line_start", k),  32'(ls[k]), 32'(e_ls));
        if (c > 0) verify_pins(k, c - 1);
      end
      pos = eff ? (pcur + 1) % (HT * VT) : 0;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
